seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle radix-2 restoring divider supplying the HI/LO result for DIV/DIVU. It sits beside the combinational ALU in the execute stage and is the division counterpart of its single-cycle MULT/MULTU path. The pipeline starts it with a one-cycle `start_i` pulse and stalls on `busy_o`. The result uses the ALU's 64-bit layout: remainder in the upper word (HI), quotient in the lower word (LO).

## Interface
- `WIDTH`, default 32: operand width; the result is `2*WIDTH`.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: synchronous reset, active-high.
- `start_i` input 1: start request; accepted only while `busy_o`=0.
- `signed_i` input 1: 1 = DIV (two's complement), 0 = DIVU; sampled when the request is accepted.
- `dividend_i` input WIDTH: src0 (rs); sampled when the request is accepted.
- `divisor_i` input WIDTH: src1 (rt); sampled when the request is accepted.
- `busy_o` output 1: a division is in progress.
- `done_o` output 1: one-cycle pulse, result valid.
- `result_o` output 2*WIDTH: {remainder, quotient}.
- `div_zero_o` output 1: the last completed division had divisor 0; valid with `done_o`, held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start_i`=1 latches the operands and `signed_i`.
  - Signed mode: converts the operands to magnitudes and records `qneg` = sign(a) XOR sign(b) and `rneg` = sign(a).
  - Clears the 2*WIDTH partial remainder and the quotient, zeroes the counter, and goes to CALC.
- CALC, one iteration per cycle:
  - Shift {rem, dividend} left by 1.
  - If the upper half is at least the divisor magnitude: subtract it and shift in quotient bit 1; otherwise shift in 0.
  - After WIDTH iterations (counter = WIDTH-1), go to FIX.
- FIX:
  - Signed mode: quotient negated if `qneg`; remainder negated if `rneg`.
  - Writes `result_o`, asserts `done_o` for the next cycle, and returns to IDLE.
- Divide by zero, either mode: the result is forced to {`dividend_i` as sampled, all-ones}, and `div_zero_o`=1.
- Signed overflow 0x80000000 / -1 gives quotient 0x80000000, remainder 0, with no flag.
- `start_i` while `busy_o`=1 is ignored, with no queuing.
- `result_o` holds its value until the next FIX write; an accepted start does not clear it.

## Timing
- Reset: state IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, `div_zero_o`=0, counter 0.
- Start accepted in cycle 0:
  - `busy_o`=1 in cycles 1–33 (CALC 1–32, FIX 33).
  - `done_o`=1 and `result_o` valid in cycle 34.
  - Latency is 34 cycles.
- `done_o` is asserted while back in IDLE. A `start_i` in that same cycle 34 is accepted, giving back-to-back throughput of one division per 34 cycles.
- `rst_i` during CALC or FIX aborts the operation: the next cycle is IDLE with the reset values, and no `done_o` is produced.
- `rst_i` has priority over a simultaneous `start_i`.

## Configuration
- `DIV_ZERO_FAST_EN`:
  - Defined: a zero divisor is detected in IDLE at acceptance and the block goes directly to FIX. `busy_o` is high in cycle 1 only; `done_o` pulses in cycle 2. The result is as specified for divide by zero.
  - Undefined: a zero divisor runs the full 34-cycle sequence with the same result and flag.

## Structure
- The shared package holds:
  - the state encoding (IDLE/CALC/FIX) as a typedef;
  - the `WIDTH` default;
  - counter width `$clog2(WIDTH)`;
  - the result field positions (HI = [2W-1:W], LO = [W-1:0]), shared with the ALU result layout.
- Sub-module `div_sign_fix`: combinational conditional two's-complement negate. Instantiated for operand magnitude (x2) and result correction (x2).

## Test plan
- Unsigned 100 / 7, start in cycle 0 -> `done_o` in cycle 34 only, `result_o`=0x00000002_0000000E, `div_zero_o`=0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> `result_o`=0xFFFFFFFF_FFFFFFFD. The same bits unsigned -> 0x00000001_7FFFFFFC.
- Signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
- 5 / 0 -> `result_o`=0x00000005_FFFFFFFF, `div_zero_o`=1. `done_o` in cycle 34, or in cycle 2 with `DIV_ZERO_FAST_EN`.
- Second `start_i` in cycle 10 with different operands -> ignored, and the first result is correct in cycle 34. A new start in cycle 34 -> next `done_o` in cycle 68.
- `rst_i` in cycle 10 -> cycle 11 `busy_o`=0, no `done_o` through cycle 40, `result_o`=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential DIV/DIVU unit: state encoding,
// default operand width, counter width and the HI/LO result layout
// that matches the ALU's 64-bit result.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    // Iteration counter width for a given operand width (at least 1 bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    // Result field positions: remainder in HI, quotient in LO.
    localparam int RES_HI_MSB = 2 * DIV_WIDTH - 1;
    localparam int RES_HI_LSB = DIV_WIDTH;
    localparam int RES_LO_MSB = DIV_WIDTH - 1;
    localparam int RES_LO_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_sign_fix.sv
// div_sign_fix: conditional two's-complement negate. Used to turn signed
// operands into magnitudes and to restore the sign of quotient/remainder.
module div_sign_fix
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Negate when requested, otherwise pass through.
    always_comb begin
        result_o = neg_i ? ((~value_i) + ONE) : value_i;
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result layout is {remainder, quotient} (HI/LO). One quotient bit per
// cycle in CALC, sign correction and result write in FIX.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and
// goes straight from IDLE to FIX.
//
// Handshake: start_i is a single-cycle request that is taken only while
// busy_o is low (a request during the done_o cycle is taken); requests
// while busy are dropped. done_o pulses for exactly one cycle when
// result_o/div_zero_o become valid; result_o then holds until the next
// completed division.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_zero_o,
    output div_state_t         state_o
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;       // upper half of the partial remainder
    logic [WIDTH-1:0] quo;       // lower half: dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dmag;      // divisor magnitude
    logic [WIDTH-1:0] a_raw;     // dividend as sampled, for the divide-by-zero result
    logic             qneg;
    logic             rneg;
    logic             zero_div;

    logic             sgn_a;
    logic             sgn_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH:0]   trial;

    assign sgn_a   = signed_i & dividend_i[WIDTH-1];
    assign sgn_b   = signed_i & divisor_i[WIDTH-1];
    assign busy_o  = (state != ST_IDLE);
    assign state_o = state;

    div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.value_i(dividend_i), .neg_i(sgn_a), .result_o(a_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.value_i(divisor_i),  .neg_i(sgn_b), .result_o(b_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.value_i(quo),        .neg_i(qneg),  .result_o(q_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.value_i(rem),        .neg_i(rneg),  .result_o(r_fix));

    // Trial subtraction of the divisor from the shifted partial remainder;
    // the extra top bit is the borrow (set when shifted value < divisor).
    always_comb begin
        trial = {rem, quo[WIDTH-1]} - {1'b0, dmag};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dmag       <= '0;
            a_raw      <= '0;
            qneg       <= 1'b0;
            rneg       <= 1'b0;
            zero_div   <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            div_zero_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        a_raw      <= dividend_i;
                        quo        <= a_mag;
                        dmag       <= b_mag;
                        rem        <= '0;
                        cnt        <= '0;
                        qneg       <= sgn_a ^ sgn_b;
                        rneg       <= sgn_a;
                        zero_div   <= (divisor_i == '0);
                        div_zero_o <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                        state      <= (divisor_i == '0) ? ST_FIX : ST_CALC;
`else
                        state      <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    if (cnt == CNT_LAST) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_FIX: begin
                    if (zero_div) begin
                        result_o   <= {a_raw, {WIDTH{1'b1}}};
                        div_zero_o <= 1'b1;
                    end else begin
                        result_o   <= {r_fix, q_fix};
                    end
                    cnt    <= '0;
                    done_o <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus randomized divisions checked
// against an arithmetic reference model.
module tb_seq_divider;
    import seq_divider_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;
    logic        div_zero_o;
    div_state_t  dbg_state;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .div_zero_o (div_zero_o),
        .state_o    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [64:0] exp_q[$];          // {div_zero, remainder, quotient}
    logic [63:0] last_result;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer division, truncating toward zero,
    // remainder takes the dividend's sign; divide by zero per the rules.
    function automatic logic [64:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] qv;
        logic [63:0] rv;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        sa = s ? {{32{a[31]}}, a} : {32'd0, a};
        sb = s ? {{32{b[31]}}, b} : {32'd0, b};
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {1'b0, rv[31:0], qv[31:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // Starts a division in the current cycle (cycle 0) and returns in the
    // cycle done_o is seen, so a following call starts back-to-back.
    // mid >= 0 drives an extra start_i in that cycle, which must be ignored.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [64:0] exp, input int mid);
        logic [64:0] e;
        int cyc;
        int exp_lat;
        int busy_bad;
        exp_q.push_back(exp);
`ifdef DIV_ZERO_FAST_EN
        exp_lat = (b == 32'd0) ? 2 : 34;
`else
        exp_lat = 34;
`endif
        start_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        tick();
        cyc      = 1;
        busy_bad = 0;
        start_i  = 1'b0;
        check("result_hold", result_o, last_result);
        check("dz_clear", {63'd0, div_zero_o}, 64'd0);
        while (cyc < 120) begin
            if (busy_o !== (cyc < exp_lat)) busy_bad++;
            if (done_o === 1'b1) break;
            if (cyc == mid) begin
                start_i    = 1'b1;
                divisor_i  = $urandom_range(1, 50);
            end else begin
                start_i    = 1'b0;
                divisor_i  = $urandom;
            end
            signed_i   = $urandom_range(0, 1);
            dividend_i = $urandom;
            tick();
            cyc++;
        end
        start_i = 1'b0;
        e = exp_q.pop_front();
        check("latency", cyc, exp_lat);
        check("result", result_o, e[63:0]);
        check("div_zero", {63'd0, div_zero_o}, {63'd0, e[64]});
        check("busy_window", busy_bad, 0);
        last_result = e[63:0];
    endtask

    // One idle cycle after a result: done_o must have dropped, result held.
    task automatic idle_check();
        start_i = 1'b0;
        tick();
        check("done_pulse", {63'd0, done_o}, 64'd0);
        check("idle_hold", result_o, last_result);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        int          done_cnt;

        rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        last_result = '0;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_dz", {63'd0, div_zero_o}, 64'd0);

        // Directed cases
        run_div(1'b0, 32'd100, 32'd7, {1'b0, 64'h00000002_0000000E}, -1);
        idle_check();
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {1'b0, 64'hFFFFFFFF_FFFFFFFD}, -1);
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, {1'b0, 64'h00000001_7FFFFFFC}, -1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 64'h00000000_80000000}, -1);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {1'b0, 64'h00000000_FFFFFFFF}, -1);
        run_div(1'b0, 32'd5, 32'd0, {1'b1, 64'h00000005_FFFFFFFF}, -1);
        idle_check();
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, {1'b1, 64'hFFFFFFFB_FFFFFFFF}, -1);
        run_div(1'b0, 32'd1000, 32'd9, {1'b0, 64'h00000001_0000006F}, 10);
        idle_check();

        // Reset in cycle 10 of a division aborts it
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        last_result = '0;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_result", result_o, 64'd0);
        check("abort_dz", {63'd0, div_zero_o}, 64'd0);
        done_cnt = 0;
        for (int c = 11; c <= 40; c++) begin
            if (done_o === 1'b1) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);

        // Reset wins over a simultaneous start
        rst_i = 1'b1; start_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd2;
        tick();
        rst_i = 1'b0; start_i = 1'b0;
        tick();
        check("rst_prio_busy", {63'd0, busy_o}, 64'd0);

        // Randomized divisions
        for (int n = 0; n < 40; n++) begin
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 200);
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 16);
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFF0;
                default: b = $urandom;
            endcase
            run_div(s, a, b, ref_div(s, a, b), -1);
            if ($urandom_range(0, 3) == 0) idle_check();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
